crp16_ex_wb: RTL and testbench
==============================

// Module: crp16_ex_wb
// PURPOSE
//  Execute->writeback stage directly downstream of the CRP16 ALU. Accepts ALU result + V/C/N/Z per op
//  via valid/ready, maintains architectural status register (flags), buffers result for regfile writer.
//  Evaluates branch condition codes against registered flags for fetch/branch unit.
// PARAMETERS
//  DATA_W   16  ALU result width
//  REG_AW   3   register-index width (8 GPRs)
// PORTS
//  clock      in   1       single clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       ALU op result valid
//  in_ready   out  1       stage can accept
//  in_data    in   DATA_W  ALU alu_out
//  in_vcnz    in   4       {v,c,n,z} from ALU
//  in_dest    in   REG_AW  destination register index
//  in_wr_en   in   1       op writes a register
//  in_set_fl  in   1       op updates status register
//  out_valid  out  1       writeback entry valid
//  out_ready  in   1       regfile writer accepts
//  out_data   out  DATA_W  result to write
//  out_dest   out  REG_AW  destination index
//  out_wr_en  out  1       write strobe qualifier
//  flags      out  4       status register {V,C,N,Z}
//  cond       in   3       condition code to evaluate
//  cond_true  out  1       combinational: cond holds on registered flags
// BEHAVIOUR
//  - Reset: flags=4'b0000, buffer empty, out_valid=0, out_data/out_dest/out_wr_en=0; in_ready=1 the cycle after reset.
//  - Reset mid-operation drops all buffered entries; no partial writeback; flags cleared.
//  - Accept = in_valid & in_ready; Drain = out_valid & out_ready. Both may occur in one cycle.
//  - Flags: on Accept with in_set_fl=1, flags <= in_vcnz next edge; independent of drain. No bypass:
//    cond_true uses registered flags only (branch after flag-setting op sees new flags 1 cycle later).
//  - Flags unchanged on Accept with in_set_fl=0, and when in_valid=0 or in_ready=0.
//  - Entry with in_wr_en=0 still occupies buffer and drains in order (keeps op ordering); out_wr_en=0.
//  - out_* stable while out_valid & ~out_ready; data FIFO order, no reordering, no loss, no duplication.
//  - Cond codes: 000 AL=1; 001 EQ=Z; 010 NE=~Z; 011 LT=N^V; 100 GE=~(N^V);
//    101 HS=C; 110 LO=~C; 111 GT=~Z&~(N^V). Carry follows ALU subtract convention (C=1: no borrow).
//  - Latency: Accept at edge k -> out_valid high after edge k (1 cycle); flags visible after edge k.
// CONFIGURATION
//  CRP16_WB_SKID_EN defined: 2-entry skid buffer, FSM EMPTY/ONE/TWO. in_ready registered (=state!=TWO).
//    EMPTY: Accept->ONE. ONE: Accept&~Drain->TWO; Drain&~Accept->EMPTY; both->ONE (new entry replaces).
//    TWO: Drain->ONE (skid entry moves to output). No Accept in TWO. Full throughput, no comb in->out ready path.
//  Undefined: single output register; in_ready = ~out_valid | out_ready (combinational);
//    Accept&Drain same cycle -> register reloads, out_valid stays 1. No skid state.
// STRUCTURE
//  crp16_pkg: localparams FL_V=3, FL_C=2, FL_N=1, FL_Z=0; cond-code localparams COND_AL..COND_GT;
//    typedef struct packed wb_entry_t {data[DATA_W], dest[REG_AW], wr_en}; skid state enum.
//  Sub-module crp16_cond_eval (combinational flags+cond -> cond_true), reused by branch unit.
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, flags=0000, cond=001 -> cond_true=0.
//  2 Accept data=16'h8000 vcnz=4'b1010 set_fl=1 dest=3 -> next cycle out_data=8000, out_dest=3,
//    flags=1010, cond=011(LT) -> 0, cond=111(GT) -> 1.
//  3 Backpressure: out_ready=0, push 3 ops (1,2,3) -> SKID: in_ready=0 after 2; else after 1;
//    release out_ready -> drains 1,2,3 in order, none lost/duplicated.
//  4 Streaming: in_valid=out_ready=1 for 100 ops, values 0..99 -> one output per cycle, in order.
//  5 set_fl=0 op with vcnz=1111 after flags=0001 -> flags stay 0001; cond=001 -> 1, cond=101 -> 0.
//  6 Reset asserted with 2 entries buffered -> next cycle out_valid=0, flags=0000, no stale drain.

Source files
------------

// File: rtl/crp16_pkg.sv
// Shared CRP16 writeback types and constants: flag bit positions, condition codes,
// the buffered writeback entry and the skid-buffer state encoding.
package crp16_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    localparam int FL_V = 3;
    localparam int FL_C = 2;
    localparam int FL_N = 1;
    localparam int FL_Z = 0;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_HS = 3'b101;
    localparam logic [2:0] COND_LO = 3'b110;
    localparam logic [2:0] COND_GT = 3'b111;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_AW-1:0] dest;
        logic              wr_en;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/crp16_cond_eval.sv
// Combinational branch-condition evaluator over a {V,C,N,Z} status word.
// Shared with the branch unit so both agree on condition semantics.
module crp16_cond_eval
    import crp16_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [2:0] i_cond,
    output logic       o_cond_true
);

    logic w_v;
    logic w_c;
    logic w_n;
    logic w_z;
    logic w_lt;

    assign w_v  = i_flags[FL_V];
    assign w_c  = i_flags[FL_C];
    assign w_n  = i_flags[FL_N];
    assign w_z  = i_flags[FL_Z];
    assign w_lt = w_n ^ w_v;

    // C=1 means "no borrow" after a subtract, so HS tests C directly.
    always_comb begin
        o_cond_true = 1'b0;
        case (i_cond)
            COND_AL: o_cond_true = 1'b1;
            COND_EQ: o_cond_true = w_z;
            COND_NE: o_cond_true = ~w_z;
            COND_LT: o_cond_true = w_lt;
            COND_GE: o_cond_true = ~w_lt;
            COND_HS: o_cond_true = w_c;
            COND_LO: o_cond_true = ~w_c;
            COND_GT: o_cond_true = ~w_z & ~w_lt;
            default: o_cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/crp16_ex_wb.sv
// CRP16 execute->writeback stage: status register, result buffer, condition evaluation.
// Define CRP16_WB_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module crp16_ex_wb
    import crp16_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [3:0]        i_in_vcnz,
    input  logic [REG_AW-1:0] i_in_dest,
    input  logic              i_in_wr_en,
    input  logic              i_in_set_fl,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [REG_AW-1:0] o_out_dest,
    output logic              o_out_wr_en,
    output logic [3:0]        o_flags,
    input  logic [2:0]        i_cond,
    output logic              o_cond_true
);

    wb_entry_t w_in_entry;
    wb_entry_t r_out_entry;
    logic      w_in_ready;
    logic      w_out_valid;
    logic      w_accept;
    logic      w_drain;
    logic [3:0] r_flags;

    assign w_in_entry = '{data: i_in_data, dest: i_in_dest, wr_en: i_in_wr_en};
    assign w_accept   = i_in_valid & w_in_ready;
    assign w_drain    = w_out_valid & i_out_ready;

    // Flags track accepted flag-setting ops only; draining has no effect on them.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_flags <= 4'b0000;
        end else if (w_accept && i_in_set_fl) begin
            r_flags <= i_in_vcnz;
        end
    end

`ifdef CRP16_WB_SKID_EN
    skid_state_t r_state;
    skid_state_t w_state_next;
    wb_entry_t   r_skid_entry;
    logic        w_load_out_in;
    logic        w_load_out_skid;
    logic        w_load_skid;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= SKID_EMPTY;
            r_out_entry  <= '0;
            r_skid_entry <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_out_in) begin
                r_out_entry <= w_in_entry;
            end else if (w_load_out_skid) begin
                r_out_entry <= r_skid_entry;
            end
            if (w_load_skid) begin
                r_skid_entry <= w_in_entry;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) begin
                    w_state_next  = SKID_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept) begin
                    w_state_next = SKID_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_drain) begin
                    w_state_next = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (w_drain) begin
                    w_state_next    = SKID_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_state_next = SKID_EMPTY;
        endcase
    end

    // Ready depends only on state, so there is no combinational out_ready->in_ready path.
    assign w_in_ready  = (r_state != SKID_TWO);
    assign w_out_valid = (r_state != SKID_EMPTY);
`else
    logic r_out_valid;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out_entry <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_entry <= w_in_entry;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w_in_ready  = ~r_out_valid | i_out_ready;
    assign w_out_valid = r_out_valid;
`endif

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_data  = r_out_entry.data;
    assign o_out_dest  = r_out_entry.dest;
    assign o_out_wr_en = r_out_entry.wr_en;
    assign o_flags     = r_flags;

    crp16_cond_eval u_cond_eval (
        .i_flags     (r_flags),
        .i_cond      (i_cond),
        .o_cond_true (o_cond_true)
    );

endmodule

// File: tb/tb_crp16_ex_wb.sv
// Directed self-checking bench for crp16_ex_wb (default and CRP16_WB_SKID_EN builds).
module tb_crp16_ex_wb;

`ifdef CRP16_WB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [15:0] i_in_data;
    logic [3:0]  i_in_vcnz;
    logic [2:0]  i_in_dest;
    logic        i_in_wr_en;
    logic        i_in_set_fl;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [15:0] o_out_data;
    logic [2:0]  o_out_dest;
    logic        o_out_wr_en;
    logic [3:0]  o_flags;
    logic [2:0]  i_cond;
    logic        o_cond_true;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] push_q[$];

    crp16_ex_wb dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_vcnz   (i_in_vcnz),
        .i_in_dest   (i_in_dest),
        .i_in_wr_en  (i_in_wr_en),
        .i_in_set_fl (i_in_set_fl),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_dest  (o_out_dest),
        .o_out_wr_en (o_out_wr_en),
        .o_flags     (o_flags),
        .i_cond      (i_cond),
        .o_cond_true (o_cond_true)
    );

    always #5 i_clock = ~i_clock;

    // One clock of traffic: offers the head of push_q and reports what handshakes happened.
    task automatic tick(output bit acc, output bit drn, output logic [15:0] dval);
        i_in_valid  = (push_q.size() != 0);
        i_in_data   = (push_q.size() != 0) ? push_q[0] : 16'h0000;
        i_in_dest   = i_in_data[2:0];
        i_in_wr_en  = 1'b1;
        i_in_set_fl = 1'b0;
        #1;
        acc  = i_in_valid && o_in_ready;
        drn  = o_out_valid && i_out_ready;
        dval = o_out_data;
        @(posedge i_clock);
        #1;
        if (acc) void'(push_q.pop_front());
        i_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_in_valid = 1'b1; i_in_data = 16'hDEAD; i_in_vcnz = 4'hF;
        i_in_dest = 3'd7; i_in_wr_en = 1'b1; i_in_set_fl = 1'b1; i_out_ready = 1'b0;
        i_cond = 3'b001;
        repeat (2) @(posedge i_clock);
        #1;
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", o_out_valid); end
        n_tests++; if (o_flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", o_flags); end
        n_tests++; if (o_cond_true !== 1'b0) begin n_fail++; $display("FAIL reset_cond_eq: got %b expected 0", o_cond_true); end
        n_tests++; if (o_out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", o_out_data); end
        i_reset = 1'b0; i_in_valid = 1'b0; i_in_set_fl = 1'b0;
        @(posedge i_clock);
        #1;
        n_tests++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", o_in_ready); end
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b expected 0", o_out_valid); end
    endtask

    task automatic test_accept();
        i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_data = 16'h8000; i_in_vcnz = 4'b1010;
        i_in_set_fl = 1'b1; i_in_dest = 3'd3; i_in_wr_en = 1'b1; i_cond = 3'b011;
        #1;
        n_tests++; if (o_flags !== 4'b0000) begin n_fail++; $display("FAIL accept_no_bypass: got %b expected 0000", o_flags); end
        @(posedge i_clock);
        #1;
        i_in_valid = 1'b0; i_in_set_fl = 1'b0;
        n_tests++; if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL accept_valid: got %b expected 1", o_out_valid); end
        n_tests++; if (o_out_data !== 16'h8000) begin n_fail++; $display("FAIL accept_data: got %h expected 8000", o_out_data); end
        n_tests++; if (o_out_dest !== 3'd3) begin n_fail++; $display("FAIL accept_dest: got %0d expected 3", o_out_dest); end
        n_tests++; if (o_out_wr_en !== 1'b1) begin n_fail++; $display("FAIL accept_wr_en: got %b expected 1", o_out_wr_en); end
        n_tests++; if (o_flags !== 4'b1010) begin n_fail++; $display("FAIL accept_flags: got %b expected 1010", o_flags); end
        i_cond = 3'b011; #1;
        n_tests++; if (o_cond_true !== 1'b0) begin n_fail++; $display("FAIL accept_cond_lt: got %b expected 0", o_cond_true); end
        i_cond = 3'b111; #1;
        n_tests++; if (o_cond_true !== 1'b1) begin n_fail++; $display("FAIL accept_cond_gt: got %b expected 1", o_cond_true); end
        @(posedge i_clock);
        #1;
        n_tests++; if (o_out_data !== 16'h8000 || o_out_valid !== 1'b1) begin n_fail++; $display("FAIL accept_stall_hold: got %h/%b expected 8000/1", o_out_data, o_out_valid); end
        i_out_ready = 1'b1;
        @(posedge i_clock);
        #1;
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL accept_drained: got %b expected 0", o_out_valid); end
        // Entry that writes no register still occupies the buffer.
        i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_data = 16'h1234; i_in_dest = 3'd5; i_in_wr_en = 1'b0;
        @(posedge i_clock);
        #1;
        i_in_valid = 1'b0; i_in_wr_en = 1'b1;
        n_tests++; if (o_out_valid !== 1'b1 || o_out_wr_en !== 1'b0 || o_out_data !== 16'h1234) begin
            n_fail++; $display("FAIL nowr_entry: got v=%b wr=%b d=%h expected v=1 wr=0 d=1234", o_out_valid, o_out_wr_en, o_out_data);
        end
        i_out_ready = 1'b1;
        @(posedge i_clock);
        #1;
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL nowr_drained: got %b expected 0", o_out_valid); end
    endtask

    task automatic test_cond();
        logic [3:0] pats[4];
        logic [7:0] exp_tab[4];
        logic [7:0] row;
        pats[0] = 4'b0000; exp_tab[0] = 8'b1101_0101;
        pats[1] = 4'b0101; exp_tab[1] = 8'b0011_0011;
        pats[2] = 4'b0010; exp_tab[2] = 8'b0100_1101;
        pats[3] = 4'b1100; exp_tab[3] = 8'b0010_1101;
        i_out_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            i_in_valid = 1'b1; i_in_set_fl = 1'b1; i_in_vcnz = pats[p]; i_in_data = 16'h00C0 + 16'(p);
            @(posedge i_clock);
            #1;
            i_in_valid = 1'b0; i_in_set_fl = 1'b0;
            n_tests++; if (o_flags !== pats[p]) begin n_fail++; $display("FAIL cond_flags_%0d: got %b expected %b", p, o_flags, pats[p]); end
            row = exp_tab[p];
            for (int c = 0; c < 8; c++) begin
                i_cond = 3'(c);
                #1;
                n_tests++;
                if (o_cond_true !== row[c]) begin
                    n_fail++; $display("FAIL cond_p%0d_c%0d: got %b expected %b", p, c, o_cond_true, row[c]);
                end
            end
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_backpressure();
        bit acc, drn;
        logic [15:0] dval;
        logic [15:0] exp_seq[3];
        int drained;
        exp_seq[0] = 16'd1; exp_seq[1] = 16'd2; exp_seq[2] = 16'd3;
        push_q = {16'd1, 16'd2, 16'd3};
        i_out_ready = 1'b0;
        tick(acc, drn, dval);
        n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_first_accept: got %b expected 1", acc); end
        n_tests++; if (o_in_ready !== SKID) begin n_fail++; $display("FAIL bp_ready_after1: got %b expected %b", o_in_ready, SKID); end
        tick(acc, drn, dval);
        n_tests++; if (acc !== SKID) begin n_fail++; $display("FAIL bp_second_accept: got %b expected %b", acc, SKID); end
        n_tests++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after2: got %b expected 0", o_in_ready); end
        tick(acc, drn, dval);
        n_tests++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_full_accept: got %b expected 0", acc); end
        n_tests++; if (o_out_data !== 16'd1) begin n_fail++; $display("FAIL bp_stall_data: got %h expected 0001", o_out_data); end
        i_out_ready = 1'b1;
        drained = 0;
        for (int cyc = 0; cyc < 20 && drained < 3; cyc++) begin
            tick(acc, drn, dval);
            if (drn) begin
                n_tests++;
                if (dval !== exp_seq[drained]) begin
                    n_fail++; $display("FAIL bp_order_%0d: got %h expected %h", drained, dval, exp_seq[drained]);
                end
                drained++;
            end
        end
        n_tests++; if (drained !== 3) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 3", drained); end
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b expected 0", o_out_valid); end
        push_q.delete();
    endtask

    task automatic test_streaming();
        bit acc, drn;
        logic [15:0] dval;
        int drained, cycles, bad;
        push_q.delete();
        for (int i = 0; i < 100; i++) push_q.push_back(16'(i));
        i_out_ready = 1'b1;
        drained = 0; cycles = 0; bad = 0;
        while (drained < 100 && cycles < 300) begin
            tick(acc, drn, dval);
            cycles++;
            if (drn) begin
                n_tests++;
                if (dval !== 16'(drained)) begin
                    n_fail++; bad++;
                    if (bad < 5) $display("FAIL stream_order_%0d: got %h expected %h", drained, dval, 16'(drained));
                end
                drained++;
            end
        end
        n_tests++; if (drained !== 100) begin n_fail++; $display("FAIL stream_count: got %0d expected 100", drained); end
        n_tests++; if (cycles !== 101) begin n_fail++; $display("FAIL stream_cycles: got %0d expected 101", cycles); end
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b expected 0", o_out_valid); end
        push_q.delete();
    endtask

    task automatic test_set_fl0();
        i_out_ready = 1'b1;
        i_in_valid = 1'b1; i_in_set_fl = 1'b1; i_in_vcnz = 4'b0001; i_in_data = 16'h0AAA;
        @(posedge i_clock);
        #1;
        n_tests++; if (o_flags !== 4'b0001) begin n_fail++; $display("FAIL setfl_load: got %b expected 0001", o_flags); end
        i_in_set_fl = 1'b0; i_in_vcnz = 4'b1111; i_in_data = 16'h0BBB;
        @(posedge i_clock);
        #1;
        i_in_valid = 1'b0;
        n_tests++; if (o_flags !== 4'b0001) begin n_fail++; $display("FAIL setfl0_hold: got %b expected 0001", o_flags); end
        n_tests++; if (o_out_data !== 16'h0BBB) begin n_fail++; $display("FAIL setfl0_data: got %h expected 0bbb", o_out_data); end
        i_cond = 3'b001; #1;
        n_tests++; if (o_cond_true !== 1'b1) begin n_fail++; $display("FAIL setfl0_cond_eq: got %b expected 1", o_cond_true); end
        i_cond = 3'b101; #1;
        n_tests++; if (o_cond_true !== 1'b0) begin n_fail++; $display("FAIL setfl0_cond_hs: got %b expected 0", o_cond_true); end
        i_in_set_fl = 1'b1;
        @(posedge i_clock);
        #1;
        i_in_set_fl = 1'b0;
        n_tests++; if (o_flags !== 4'b0001) begin n_fail++; $display("FAIL setfl_idle_hold: got %b expected 0001", o_flags); end
    endtask

    task automatic test_reset_mid();
        bit acc, drn;
        logic [15:0] dval;
        int drains;
        i_out_ready = 1'b0;
        push_q = {16'h00AA, 16'h00BB};
        tick(acc, drn, dval);
        tick(acc, drn, dval);
        push_q.delete();
        n_tests++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got %b expected 0", o_in_ready); end
        i_in_valid = 1'b1; i_in_set_fl = 1'b1; i_in_vcnz = 4'b0110; i_in_data = 16'h0CCC;
        @(posedge i_clock);
        #1;
        i_in_valid = 1'b0; i_in_set_fl = 1'b0;
        n_tests++; if (o_flags !== 4'b0001) begin n_fail++; $display("FAIL rmid_blocked_flags: got %b expected 0001", o_flags); end
        n_tests++; if (o_out_data !== 16'h00AA) begin n_fail++; $display("FAIL rmid_head: got %h expected 00aa", o_out_data); end
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", o_out_valid); end
        n_tests++; if (o_flags !== 4'b0000) begin n_fail++; $display("FAIL rmid_flags: got %b expected 0000", o_flags); end
        i_out_ready = 1'b1;
        drains = 0;
        for (int i = 0; i < 3; i++) begin
            tick(acc, drn, dval);
            if (drn) drains++;
        end
        n_tests++; if (drains !== 0) begin n_fail++; $display("FAIL rmid_stale_drain: got %0d expected 0", drains); end
        push_q = {16'h0055};
        drains = 0;
        for (int i = 0; i < 10 && drains == 0; i++) begin
            tick(acc, drn, dval);
            if (drn) begin
                drains++;
                n_tests++; if (dval !== 16'h0055) begin n_fail++; $display("FAIL rmid_fresh_data: got %h expected 0055", dval); end
            end
        end
        n_tests++; if (drains !== 1) begin n_fail++; $display("FAIL rmid_fresh_count: got %0d expected 1", drains); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_accept();
        test_cond();
        test_backpressure();
        test_streaming();
        test_set_fl0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
